stream_reverse_scheduler: RTL and testbench
===========================================

STREAM_REVERSE_SCHEDULER -- requirements
Module: stream_reverse_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning words per reversal block (N >= 2).
REQ-002 The block SHALL have parameter NREQ, default 4, meaning number of requesters sharing the reversal buffer (NREQ >= 1).
REQ-003 The block SHALL have parameter W, default 32, meaning data word width.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port req_valid, input, NREQ bits: per-requester word-valid.
REQ-007 Port req_data, input, NREQ*W bits: requester i data in bits [i*W +: W].
REQ-008 Port req_ready, output, NREQ bits: per-requester word-accept.
REQ-009 Port out_data, output, W bits: reversed output word.
REQ-010 Port out_id, output, max(1,clog2(NREQ)) bits: index of the requester that sourced the block being drained.
REQ-011 Port out_valid, output, 1 bit: out_data/out_id/out_last valid.
REQ-012 Port out_ready, input, 1 bit: downstream accept.
REQ-013 Port out_last, output, 1 bit: final word of the reversed block.
REQ-014 Port busy, output, 1 bit: high in FILL or DRAIN.

Function
REQ-015 The FSM SHALL have states IDLE, FILL, DRAIN; it SHALL enter IDLE on reset.
REQ-016 In IDLE, req_ready SHALL be all-zero and out_valid SHALL be 0.
REQ-017 In IDLE, if any req_valid bit is 1, the block SHALL grant the first asserted requester at or after index ptr (wrapping from NREQ-1 to 0), register it as grant, clear count to 0, and move to FILL next cycle.
REQ-018 In FILL, req_ready SHALL be 1 only at bit grant (combinational from state); every other bit SHALL be 0.
REQ-019 In FILL, each cycle with req_valid[grant] && req_ready[grant] SHALL write req_data word grant into buffer slot count and increment count.
REQ-020 The accept that writes slot N-1 SHALL move the FSM to DRAIN with count = N-1; no grant change or preemption is allowed during FILL.
REQ-021 If req_valid[grant] is low during FILL, the block SHALL stall indefinitely with count held; there is no timeout.
REQ-022 In DRAIN, out_valid SHALL be 1, out_data SHALL be buffer[count], out_id SHALL be grant, and out_last SHALL be 1 only when count == 0.
REQ-023 In DRAIN, each cycle with out_ready high SHALL decrement count; when out_ready is low, all outputs SHALL remain stable.
REQ-024 An accepted word with out_last = 1 SHALL return the FSM to IDLE and set ptr = grant+1 mod NREQ (round-robin).
REQ-025 Latency: the first reversed word SHALL be valid the cycle after the Nth input accept; the minimum block period is 2N+1 cycles.
REQ-026 Output order SHALL be the exact reverse of accept order within a block; blocks SHALL never interleave.
REQ-027 busy SHALL be 1 in FILL and DRAIN and 0 in IDLE.
REQ-028 count SHALL be clog2(N) bits wide with no wrap past N-1 or below 0.

Reset
REQ-029 Asserting rst at any time SHALL asynchronously force state IDLE, count 0, grant 0, ptr 0, req_ready 0, out_valid 0, out_last 0, out_data 0, out_id 0, and busy 0.
REQ-030 A partially filled or partially drained block SHALL be discarded on reset; buffer contents need not be cleared.

Verification
REQ-031 Single block: N=4; requester 2 sends 1,2,3,4 back-to-back with out_ready=1 -> out_data 4,3,2,1 on consecutive cycles, out_id=2, out_last on word 1 only.
REQ-032 Round-robin: all four req_valid held high with continuous data -> grants in order 0,1,2,3,0; ptr wraps from 3 to 0.
REQ-033 Fill stall: requester 0 drops req_valid after 2 words for 5 cycles, then sends 2 more -> count holds at 2, output is word4,word3,word2,word1.
REQ-034 Backpressure: out_ready low for 3 cycles mid-drain -> out_data, out_id and out_last stable for all 3 cycles; no word lost or duplicated.
REQ-035 Non-granted isolation: requester 1 asserts valid while requester 0 fills -> req_ready[1] stays 0 until requester 0's block out_last is accepted.
REQ-036 Reset mid-block: rst pulsed after 2 of 4 words accepted -> outputs at reset values immediately; the next block from a fresh requester drains correctly.

Source files
------------

// File: rtl/stream_reverse_scheduler.sv
// Round-robin shared reversal buffer: grants one requester, fills N words,
// then drains them in reverse order with registered outputs.
module stream_reverse_scheduler #(
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int W    = 32,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      out_data,
  output logic [IDW-1:0]    out_id,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state;
  logic [CW-1:0]  count;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] ptr;
  logic [W-1:0]   mem [N];
  logic [W-1:0]   wdata;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] cand;
  logic           any;
  logic [IDW-1:0] ptr_next;

  assign wdata    = req_data[grant*W +: W];
  assign busy     = (state != IDLE);
  assign ptr_next = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    req_ready = '0;
    if (state == FILL) req_ready[grant] = 1'b1;
  end

  // First asserted requester at or after ptr, wrapping around.
  always_comb begin
    sel  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!any && req_valid[cand]) begin
        any = 1'b1;
        sel = cand;
      end
    end
  end

  // Buffer holds no reset; stale contents are never presented.
  always_ff @(posedge clk) begin
    if (state == FILL && req_valid[grant]) mem[count] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      grant     <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            grant <= sel;
            count <= '0;
            state <= FILL;
          end
        end
        FILL: begin
          if (req_valid[grant]) begin
            if (count == LAST) begin
              // Slot N-1 is presented straight from the input to save a cycle.
              state     <= DRAIN;
              out_valid <= 1'b1;
              out_data  <= wdata;
              out_id    <= grant;
              out_last  <= 1'b0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (count == '0) begin
              state     <= IDLE;
              ptr       <= ptr_next;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              out_id    <= '0;
            end else begin
              count    <= count - 1'b1;
              out_data <= mem[count - 1'b1];
              out_last <= (count == CW'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_reverse_scheduler.sv
// Bench for stream_reverse_scheduler: per-requester source queues, an output
// scoreboard, a block table and directed stall/backpressure/reset sequences.
module tb_stream_reverse_scheduler;

  localparam int N = 4, NREQ = 4, W = 32;

  logic          clk, rst;
  logic [3:0]    req_valid;
  logic [127:0]  req_data;
  logic [3:0]    req_ready;
  logic [31:0]   out_data;
  logic [1:0]    out_id;
  logic          out_valid, out_ready, out_last, busy;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  id;
    logic        last;
  } exp_t;

  typedef struct {
    int unsigned rid;
    logic [31:0] base;
    logic [1:0]  exp_id;
  } vec_t;

  exp_t        sb [$];
  logic [31:0] srcbuf [4][64];
  int unsigned head [4];
  int unsigned tail [4];
  logic        hs [4];
  int          checks = 0;
  int          errors = 0;
  logic        r0_done = 1'b0;

  stream_reverse_scheduler #(.N(N), .NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_data(out_data), .out_id(out_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input int r, input logic [31:0] w);
    srcbuf[r][tail[r] % 64] = w;
    tail[r]++;
  endtask

  // Loads a 4-word block for requester r and queues its reversed output.
  task automatic send_block(input int r, input logic [31:0] base);
    for (int k = 0; k < 4; k++) load(r, base + 32'(k));
    for (int k = 3; k >= 0; k--) sb.push_back('{base + 32'(k), 2'(r), k == 0});
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < 4; i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    bit done = 1'b0;
    while (!done && n < 400) begin
      @(negedge clk); #1;
      n++;
      done = (sb.size() == 0) && !busy && srcs_empty();
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic wait_src_left(input int r, input int unsigned left, input string name);
    int unsigned n = 0;
    while ((tail[r] - head[r]) != left && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, tail[r] - head[r], left);
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
  endtask

  // Requester models: present head word, retire it after a sampled handshake.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (hs[i] && head[i] != tail[i]) head[i]++;
    for (int i = 0; i < 4; i++) begin
      req_valid[i]          = (head[i] != tail[i]);
      req_data[i*32 +: 32]  = srcbuf[i][head[i] % 64];
    end
    #3;
    for (int i = 0; i < 4; i++) hs[i] = req_valid[i] && req_ready[i] && !rst;
  end

  // Output monitor: every accepted word is popped from the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h id %0d expected none", out_data, out_id);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_id", 32'(out_id), 32'(e.id));
        chk("out_last", 32'(out_last), 32'(e.last));
        if (out_last && out_id == 2'd0) r0_done = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [4];
    bit viol, seen1;
    int unsigned n;

    tbl[0] = '{2, 32'h0000_0001, 2'd2};
    tbl[1] = '{0, 32'h0000_00A0, 2'd0};
    tbl[2] = '{3, 32'hFFFF_FFFC, 2'd3};
    tbl[3] = '{1, 32'h5555_0000, 2'd1};

    for (int i = 0; i < 4; i++) begin
      head[i] = 0; tail[i] = 0; hs[i] = 1'b0;
    end
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;
    rst       = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", 32'(out_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    rst = 1'b0;

    // Single blocks: latency, back-to-back drain, then idle.
    foreach (tbl[v]) begin
      @(negedge clk); #1;
      for (int k = 0; k < 4; k++) load(int'(tbl[v].rid), tbl[v].base + 32'(k));
      for (int k = 3; k >= 0; k--) sb.push_back('{tbl[v].base + 32'(k), tbl[v].exp_id, k == 0});
      wait_src_left(int'(tbl[v].rid), 0, "tbl_fill");
      for (int c = 0; c < 4; c++) begin
        chk("tbl_drain_valid", 32'(out_valid), 1);
        @(negedge clk); #1;
      end
      chk("tbl_idle_valid", 32'(out_valid), 0);
      chk("tbl_idle_busy", 32'(busy), 0);
    end

    // Fill stall: two words, five idle cycles, two more words.
    @(negedge clk); #1;
    load(0, 32'h0000_0011); load(0, 32'h0000_0012);
    for (int k = 3; k >= 0; k--) sb.push_back('{32'h0000_0011 + 32'(k), 2'd0, k == 0});
    wait_src_left(0, 0, "stall_first_half");
    repeat (5) begin
      @(negedge clk); #1;
      chk("stall_out_valid", 32'(out_valid), 0);
      chk("stall_busy", 32'(busy), 1);
      chk("stall_req_ready", 32'(req_ready), 32'h1);
    end
    load(0, 32'h0000_0013); load(0, 32'h0000_0014);
    wait_idle("stall_done");

    // Backpressure: out_ready low for three cycles after the first word.
    @(negedge clk); #1;
    send_block(1, 32'hBEEF_0000);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("bp_first_valid", 32'(out_valid), 1);
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #3;
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_data", out_data, sb[0].d);
      chk("bp_hold_id", 32'(out_id), 32'(sb[0].id));
      chk("bp_hold_last", 32'(out_last), 32'(sb[0].last));
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_idle("bp_done");

    // Non-granted isolation: requester 1 waits for requester 0's last word.
    do_reset();
    @(negedge clk); #1;
    r0_done = 1'b0;
    send_block(0, 32'h0A0A_0000);
    @(negedge clk); #1;
    send_block(1, 32'h0B0B_0000);
    viol = 1'b0; seen1 = 1'b0; n = 0;
    while ((sb.size() != 0 || busy || !srcs_empty()) && n < 200) begin
      @(negedge clk); #2;
      n++;
      if (req_ready[1] && !r0_done) viol = 1'b1;
      if (req_ready[1]) seen1 = 1'b1;
    end
    chk("iso_no_early_ready", 32'(viol), 0);
    chk("iso_req1_served", 32'(seen1), 1);
    wait_idle("iso_done");

    // Round robin with every requester streaming: 0,1,2,3 then back to 0.
    do_reset();
    @(negedge clk); #1;
    send_block(0, 32'h1000_0000);
    send_block(1, 32'h2000_0000);
    send_block(2, 32'h3000_0000);
    send_block(3, 32'h4000_0000);
    for (int k = 0; k < 4; k++) load(0, 32'h1000_0010 + 32'(k));
    for (int k = 3; k >= 0; k--) sb.push_back('{32'h1000_0010 + 32'(k), 2'd0, k == 0});
    wait_idle("rr_done");

    // Reset mid-fill: outputs clear at once; a fresh requester then works.
    @(negedge clk); #1;
    for (int k = 0; k < 4; k++) load(2, 32'hDEAD_0000 + 32'(k));
    wait_src_left(2, 2, "mid_two_accepted");
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_id", 32'(out_id), 0);
    chk("mid_rst_last", 32'(out_last), 0);
    head[2] = tail[2];
    @(negedge clk); #1 rst = 1'b0;
    send_block(3, 32'h0C0F_FEE0);
    wait_idle("mid_fresh_block");

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
